// File: rtl/pe_stream_pkg.sv
// Shared types and constants for the stream PE MAC.
//   prec_e     : SIMD precision select (8/4/2-bit lanes; code 3 behaves as 8-bit)
//   state_e    : job FSM states
//   SAT_*      : requantisation saturation bounds per precision
//   lane_count : number of SIMD lanes for a precision code
package pe_stream_pkg;

  typedef enum logic [1:0] {
    PREC_8B = 2'd0,
    PREC_4B = 2'd1,
    PREC_2B = 2'd2
  } prec_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int SAT_MAX_8B = 127;
  localparam int SAT_MIN_8B = -128;
  localparam int SAT_MAX_4B = 7;
  localparam int SAT_MIN_4B = -8;
  localparam int SAT_MAX_2B = 1;
  localparam int SAT_MIN_2B = -2;

  function automatic int unsigned lane_count(input logic [1:0] prec);
    case (prec)
      PREC_4B: return 2;
      PREC_2B: return 4;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/pe_stream_mac_if.sv
// Handshake bundle for the stream PE MAC: config, input beat and result channels.
//   master : producer/consumer side (streamers + output collector)
//   slave  : PE side
interface pe_stream_mac_if #(
  parameter int unsigned ACT_W   = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned SHIFT_W = 5
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [LEN_W-1:0]   cfg_len;
  logic [1:0]         cfg_precision;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               cfg_relu;
  logic [ACC_W-1:0]   cfg_bias;

  logic               in_valid;
  logic               in_ready;
  logic [ACT_W-1:0]   in_act;
  logic [ACT_W-1:0]   in_wt;

  logic               out_valid;
  logic               out_ready;
  logic [ACT_W-1:0]   out_data;
  logic [ACC_W-1:0]   out_acc;

  modport master (
    output cfg_valid, cfg_len, cfg_precision, cfg_shift, cfg_relu, cfg_bias,
    output in_valid, in_act, in_wt, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, out_acc
  );

  modport slave (
    input  cfg_valid, cfg_len, cfg_precision, cfg_shift, cfg_relu, cfg_bias,
    input  in_valid, in_act, in_wt, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, out_acc
  );
endinterface

// File: rtl/pe_simd_mul.sv
// Combinational precision-scalable signed dot-product multiplier.
//   act, wt    : packed signed lanes (lane i = bits [i*w +: w])
//   precision  : 0=one 8b lane, 1=two 4b lanes, 2=four 2b lanes, 3=as 0
//   product_c  : sum of lane products, sign-extended to ACC_W
module pe_simd_mul
  import pe_stream_pkg::*;
#(
  parameter int unsigned ACT_W = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic [ACT_W-1:0] act,
  input  logic [ACT_W-1:0] wt,
  input  logic [1:0]       precision,
  output logic [ACC_W-1:0] product_c
);
  localparam int unsigned W4 = ACT_W / 2;
  localparam int unsigned W2 = ACT_W / 4;

  logic signed [ACC_W-1:0] p8, p4, p2;
  logic signed [W4-1:0]    a4, b4;
  logic signed [W2-1:0]    a2, b2;

  // All three lane splits are computed; precision only selects the sum.
  always_comb begin
    p8 = ACC_W'($signed(act)) * ACC_W'($signed(wt));
    p4 = '0;
    a4 = '0;
    b4 = '0;
    for (int i = 0; i < 2; i++) begin
      a4 = act[i*W4 +: W4];
      b4 = wt[i*W4 +: W4];
      p4 = p4 + ACC_W'(a4) * ACC_W'(b4);
    end
    p2 = '0;
    a2 = '0;
    b2 = '0;
    for (int i = 0; i < 4; i++) begin
      a2 = act[i*W2 +: W2];
      b2 = wt[i*W2 +: W2];
      p2 = p2 + ACC_W'(a2) * ACC_W'(b2);
    end
    case (precision)
      PREC_4B: product_c = p4;
      PREC_2B: product_c = p2;
      default: product_c = p8;
    endcase
  end
endmodule

// File: rtl/pe_stream_mac.sv
// Sequential precision-scalable MAC processing element.
// Loads a bias, accumulates cfg_len activation/weight beats through a
// registered product stage, then requantises (shift, round, ReLU, saturate).
//   clk, reset : clock, asynchronous active-low reset
//   bus        : config / input beat / result handshakes (slave side)
//   busy       : job in progress (state != IDLE)
module pe_stream_mac
  import pe_stream_pkg::*;
#(
  parameter int unsigned ACT_W   = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  pe_stream_mac_if.slave bus,
  output logic           busy
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ACCUM = ACCUM;
  localparam logic [1:0] S_FLUSH = FLUSH;
  localparam logic [1:0] S_OUT   = OUT;

  logic [1:0]         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d, len_q, len_d;
  logic [1:0]         prec_q, prec_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               relu_q, relu_d;
  logic [ACC_W-1:0]   prod_q, prod_d;
  logic               prod_v_q, prod_v_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ACT_W-1:0]   out_data_q, out_data_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic               busy_q, busy_d;

  logic [ACC_W-1:0]        mul_c;
  logic signed [ACC_W-1:0] shr_c, half_c, rnd_c, relu_c, sat_c, smax_c, smin_c;
  logic [ACT_W-1:0]        req_data_c;

  pe_simd_mul #(.ACT_W(ACT_W), .ACC_W(ACC_W)) u_mul (
    .act       (bus.in_act),
    .wt        (bus.in_wt),
    .precision (prec_q),
    .product_c (mul_c)
  );

  // Requantise the accumulator: round-half-up shift, ReLU, lane saturation.
  always_comb begin
    shr_c  = $signed(acc_q) >>> shift_q;
    half_c = $signed(acc_q) >>> (shift_q - SHIFT_W'(1));
    rnd_c  = shr_c;
    if (shift_q != '0) rnd_c = shr_c + ACC_W'(half_c[0]);
    relu_c = rnd_c;
    if (relu_q && rnd_c[ACC_W-1]) relu_c = '0;
    case (prec_q)
      PREC_4B: begin smax_c = ACC_W'(SAT_MAX_4B); smin_c = ACC_W'(SAT_MIN_4B); end
      PREC_2B: begin smax_c = ACC_W'(SAT_MAX_2B); smin_c = ACC_W'(SAT_MIN_2B); end
      default: begin smax_c = ACC_W'(SAT_MAX_8B); smin_c = ACC_W'(SAT_MIN_8B); end
    endcase
    sat_c = relu_c;
    if (relu_c > smax_c)      sat_c = smax_c;
    else if (relu_c < smin_c) sat_c = smin_c;
    req_data_c = ACT_W'(sat_c);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    prec_d      = prec_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    prod_d      = prod_q;
    prod_v_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_acc_d   = out_acc_q;

    if (prod_v_q) acc_d = acc_q + prod_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_valid && cfg_ready_q) begin
          len_d   = bus.cfg_len;
          prec_d  = bus.cfg_precision;
          shift_d = bus.cfg_shift;
          relu_d  = bus.cfg_relu;
          acc_d   = bus.cfg_bias;
          cnt_d   = '0;
          state_d = (bus.cfg_len != '0) ? S_ACCUM : S_FLUSH;
        end
      end
      S_ACCUM: begin
        if (bus.in_valid && in_ready_q) begin
          prod_d   = mul_c;
          prod_v_d = 1'b1;
          cnt_d    = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // The last product lands in acc on the cycle prod_v drops.
        if (!prod_v_q) begin
          out_data_d  = req_data_c;
          out_acc_d   = acc_q;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ready flags follow the next state so a new cfg waits one cycle after out.
    cfg_ready_d = (state_d == S_IDLE);
    in_ready_d  = (state_d == S_ACCUM) && (cnt_d < len_d);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      prec_q      <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      cfg_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      prec_q      <= prec_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      cfg_ready_q <= cfg_ready_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_acc_q   <= out_acc_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_acc   = out_acc_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_pe_stream_mac.sv
// Self-checking bench for pe_stream_mac: directed jobs, an arithmetic
// reference model feeding a result scoreboard, and literal expectations.
module tb_pe_stream_mac;
  logic clk = 1'b0;
  logic reset;
  logic busy;

  pe_stream_mac_if #(.ACT_W(8), .ACC_W(32), .LEN_W(16), .SHIFT_W(5)) bif ();

  pe_stream_mac #(.ACT_W(8), .ACC_W(32), .LEN_W(16), .SHIFT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [31:0] acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] acts[8];
  logic [7:0] wts[8];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, actual, required, $time);
    end
  endtask

  function automatic int lane(input logic [7:0] x, input int i, input int w);
    int v;
    v = (int'(x) >> (i * w)) & ((1 << w) - 1);
    if (v >= (1 << (w - 1))) v -= (1 << w);
    return v;
  endfunction

  // Reference: dot products onto bias (32-bit wrap), then rounded division by 2^shift.
  function automatic exp_t model(input int len, input int prec, input int shift,
                                 input bit relu, input int bias);
    exp_t   e;
    int     acc, w, lanes;
    longint r, hi, lo;
    w     = (prec == 1) ? 4 : (prec == 2) ? 2 : 8;
    lanes = 8 / w;
    acc   = bias;
    for (int b = 0; b < len; b++)
      for (int i = 0; i < lanes; i++)
        acc += lane(acts[b], i, w) * lane(wts[b], i, w);
    r = longint'(acc);
    if (shift > 0) r = (r + (longint'(1) << (shift - 1))) >>> shift;
    if (relu && r < 0) r = 0;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    e.data = 8'(r);
    e.acc  = 32'(acc);
    return e;
  endfunction

  // Scoreboard compare: every cycle a result is presented.
  always @(negedge clk) begin
    if (reset === 1'b1 && bif.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(bif.out_valid), 32'd0);
      end else begin
        chk("sb_out_data", 32'(bif.out_data), 32'(exp_q[0].data));
        chk("sb_out_acc", bif.out_acc, exp_q[0].acc);
        if (bif.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_vals(input string name);
    chk({name, "_cfg_ready"}, 32'(bif.cfg_ready), 32'd1);
    chk({name, "_in_ready"}, 32'(bif.in_ready), 32'd0);
    chk({name, "_out_valid"}, 32'(bif.out_valid), 32'd0);
    chk({name, "_out_data"}, 32'(bif.out_data), 32'd0);
    chk({name, "_out_acc"}, bif.out_acc, 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic send_cfg(input int len, input int prec, input int shift, input bit relu,
                          input int bias, input string name);
    bit hs = 1'b0;
    int n = 0;
    bif.cfg_valid     = 1'b1;
    bif.cfg_len       = 16'(len);
    bif.cfg_precision = 2'(prec);
    bif.cfg_shift     = 5'(shift);
    bif.cfg_relu      = relu;
    bif.cfg_bias      = 32'(bias);
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bif.cfg_ready;
      @(posedge clk); #1;
      n++;
    end
    bif.cfg_valid = 1'b0;
    if (!hs) chk({name, "_cfg_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic send_beat(input int b, input string name);
    bit hs = 1'b0;
    int n = 0;
    bif.in_valid = 1'b1;
    bif.in_act   = acts[b];
    bif.in_wt    = wts[b];
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bif.in_ready;
      @(posedge clk); #1;
      n++;
    end
    bif.in_valid = 1'b0;
    if (!hs) chk({name, "_beat_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_job(input int len, input int prec, input int shift, input bit relu,
                         input int bias, input int hold, input bit gap,
                         input int exp_acc, input logic [7:0] exp_data,
                         input int exp_lat, input string name);
    int lat = 0;
    bit seen = 1'b0;
    exp_q.push_back(model(len, prec, shift, relu, bias));
    send_cfg(len, prec, shift, relu, bias, name);
    for (int b = 0; b < len; b++) begin
      if (gap && b == 1) begin @(posedge clk); #1; end
      send_beat(b, name);
    end
    while (!seen && lat < 50) begin
      @(negedge clk);
      seen = bif.out_valid;
      if (!seen) begin @(posedge clk); #1; lat++; end
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_acc_lit"}, bif.out_acc, 32'(exp_acc));
    chk({name, "_data_lit"}, 32'(bif.out_data), 32'(exp_data));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bif.cfg_valid = 1'b1;
      bif.in_valid  = 1'b1;
      @(negedge clk);
      chk({name, "_hold_cfg_ready"}, 32'(bif.cfg_ready), 32'd0);
      chk({name, "_hold_in_ready"}, 32'(bif.in_ready), 32'd0);
      chk({name, "_hold_out_valid"}, 32'(bif.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bif.cfg_valid = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    bif.out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_rel_out_valid"}, 32'(bif.out_valid), 32'd0);
    chk({name, "_rel_busy"}, 32'(busy), 32'd0);
    chk({name, "_rel_cfg_ready"}, 32'(bif.cfg_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0;
    bif.cfg_valid = 1'b0; bif.cfg_len = '0; bif.cfg_precision = '0;
    bif.cfg_shift = '0; bif.cfg_relu = 1'b0; bif.cfg_bias = '0;
    bif.in_valid = 1'b0; bif.in_act = '0; bif.in_wt = '0; bif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 8b dot product: 10 - 18 - 28 = -36
    acts[0] = 8'd2; acts[1] = 8'hFD; acts[2] = 8'd4;
    wts[0]  = 8'd5; wts[1]  = 8'd6;  wts[2]  = 8'hF9;
    run_job(3, 0, 0, 1'b0, 0, 0, 1'b0, -36, 8'hDC, 2, "t8b");
    run_job(3, 0, 0, 1'b0, 10, 0, 1'b1, -26, 8'hE6, 2, "t8b_bias_gap");

    // 4b: lane0 (-1)*2 + lane1 7*7 = 47, saturates to 7
    acts[0] = 8'h7F; wts[0] = 8'h72;
    run_job(1, 1, 0, 1'b0, 0, 0, 1'b0, 47, 8'h07, 2, "t4b");
    run_job(1, 1, 0, 1'b0, 100, 0, 1'b0, 147, 8'h07, 2, "t4b_sat");

    // Bias-only jobs: shift with rounding, ReLU, negative saturation
    run_job(0, 0, 3, 1'b0, 1000, 0, 1'b0, 1000, 8'd125, 1, "shr_exact");
    run_job(0, 0, 3, 1'b0, 1004, 0, 1'b0, 1004, 8'd126, 1, "shr_round");
    run_job(0, 0, 3, 1'b0, -1004, 0, 1'b0, -1004, 8'h83, 1, "shr_neg");
    run_job(0, 0, 0, 1'b1, -50, 0, 1'b0, -50, 8'h00, 1, "relu");
    run_job(0, 0, 0, 1'b0, -500, 0, 1'b0, -500, 8'h80, 1, "sat_neg");

    // Precision code 3 behaves as 8b: -2*100 = -200 -> -128
    acts[0] = 8'hFE; wts[0] = 8'd100;
    run_job(1, 3, 0, 1'b0, 0, 0, 1'b0, -200, 8'h80, 2, "prec3");

    // Accumulator wraps without saturation
    acts[0] = 8'd1; wts[0] = 8'd1;
    run_job(1, 0, 0, 1'b0, 2147483647, 0, 1'b0, 32'h8000_0000, 8'h80, 2, "wrap");

    // 2b: lanes (1,-1,-2,1)x(-1,-2,1,-1) = -2 per beat; held output for 5 cycles
    acts[0] = 8'h6D; acts[1] = 8'h6D; wts[0] = 8'hDB; wts[1] = 8'hDB;
    run_job(2, 2, 0, 1'b0, 0, 5, 1'b1, -4, 8'hFE, 2, "t2b_hold");

    // Abort mid-accumulation, then run a fresh job
    for (int i = 0; i < 4; i++) begin acts[i] = 8'd1; wts[i] = 8'd1; end
    send_cfg(4, 0, 0, 1'b0, 0, "abort");
    send_beat(0, "abort");
    send_beat(1, "abort");
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_vals("abort_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    acts[0] = 8'd3; wts[0] = 8'hFC;
    run_job(1, 0, 0, 1'b0, 5, 0, 1'b0, -7, 8'hF9, 2, "fresh");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
